// File: rtl/disp_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_if
// Bundles the signals between the display scan controller and its surroundings.
// The sources (time/setting logic) drive segment data and requests; the
// controller returns the grant pulse, the source select, the scan tick and the
// four registered segment patterns for the scan driver.
//
// Signals
//   aData     32  source A segments, [7:0]=digit1 ... [31:24]=digit4
//   bData     32  source B segments, same packing
//   bReq       1  level, source B requests the display
//   bAck       1  one-cycle pulse when B is granted
//   blinkMask  4  bit n blinks digit n+1
//   blank      1  level, forces every digit dark
//   src        1  0 = A shown, 1 = B shown
//   enable     1  one-clock scan tick to the scan driver
//   l1..l4     8  segment patterns for digits 1..4 (active-low segments)
//
// Modports
//   master : the side feeding the controller (sources and scan driver)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface disp_scan_ctrl_if;
    logic [31:0] aData;
    logic [31:0] bData;
    logic        bReq;
    logic        bAck;
    logic [3:0]  blinkMask;
    logic        blank;
    logic        src;
    logic        enable;
    logic [7:0]  l1;
    logic [7:0]  l2;
    logic [7:0]  l3;
    logic [7:0]  l4;

    modport master (
        output aData, bData, bReq, blinkMask, blank,
        input  bAck, src, enable, l1, l2, l3, l4
    );

    modport slave (
        input  aData, bData, bReq, blinkMask, blank,
        output bAck, src, enable, l1, l2, l3, l4
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Sits in front of the 4-digit 7-segment scan driver. It divides the system
// clock down to the scan tick, arbitrates the display between source A (normal
// time) and source B (settings/messages, request/ack with a minimum display
// time), applies per-digit blink and global blank, and presents registered
// segment patterns that only change on scan ticks.
//
// Ports
//   i_clk    1   system clock, everything on the rising edge
//   i_reset  1   synchronous active-high reset
//   io_bus   -   disp_scan_ctrl_if.slave (data, request/ack, blink, blank,
//                source select, scan tick, L1..L4)
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter logic [15:0] PRESCALE    = 16'd50000,
    parameter logic [7:0]  BLINK_TICKS = 8'd125,
    parameter logic [7:0]  HOLD_TICKS  = 8'd250,
    parameter logic [7:0]  BLANK_PAT   = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    disp_scan_ctrl_if.slave   io_bus
);

    typedef enum logic {
        SHOW_A,
        GRANT_B
    } state_t;

    state_t          r_state;
    logic [15:0]     r_pcnt;
    logic [7:0]      r_bcnt;
    logic [7:0]      r_hold;
    logic            r_phase;
    logic            r_src;
    logic            r_ack;
    logic            r_enable;
    logic [3:0][7:0] r_l;

    logic            w_tick;
    logic            w_grant;
    logic            w_release;
    logic            w_srcNext;
    logic [3:0][7:0] w_nextL;

    // The scan tick is the last count of the prescaler; ENABLE is its
    // registered copy, so the outputs change in the same cycle ENABLE rises.
    assign w_tick = (r_pcnt == PRESCALE - 16'd1);

    // Hold is compared in its registered form, so B is released on the first
    // edge after the hold count has reached its limit with the request gone.
    assign w_grant   = (r_state == SHOW_A) && io_bus.bReq;
    assign w_release = (r_state == GRANT_B) && (r_hold == HOLD_TICKS) && !io_bus.bReq;
    assign w_srcNext = w_grant | (r_src & ~w_release);

    // Digit patterns use the source selected by this edge's arbitration, but
    // the blink phase from before the edge.
    always_comb begin
        w_nextL = '0;
        for (int d = 0; d < 4; d++) begin
            if (io_bus.blank || (r_phase && io_bus.blinkMask[d])) begin
                w_nextL[d] = BLANK_PAT;
            end else if (w_srcNext) begin
                w_nextL[d] = io_bus.bData[8*d +: 8];
            end else begin
                w_nextL[d] = io_bus.aData[8*d +: 8];
            end
        end
    end

    // Prescaler, blink timer, arbitration FSM and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pcnt   <= '0;
            r_enable <= 1'b0;
            r_bcnt   <= '0;
            r_phase  <= 1'b0;
            r_state  <= SHOW_A;
            r_hold   <= '0;
            r_src    <= 1'b0;
            r_ack    <= 1'b0;
            r_l      <= {4{BLANK_PAT}};
        end else begin
            r_pcnt   <= w_tick ? 16'd0 : r_pcnt + 16'd1;
            r_enable <= w_tick;
            r_ack    <= 1'b0;

            if (w_tick) begin
                if (r_bcnt == BLINK_TICKS - 8'd1) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 8'd1;
                end
                r_l <= w_nextL;
            end

            case (r_state)
                SHOW_A: begin
                    if (w_grant) begin
                        r_state <= GRANT_B;
                        r_ack   <= 1'b1;
                        r_hold  <= '0;
                        r_src   <= 1'b1;
                    end
                end
                GRANT_B: begin
                    if (w_release) begin
                        r_state <= SHOW_A;
                        r_src   <= 1'b0;
                    end else if (w_tick && (r_hold != HOLD_TICKS)) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= SHOW_A;
                    r_src   <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.bAck   = r_ack;
    assign io_bus.src    = r_src;
    assign io_bus.enable = r_enable;
    assign io_bus.l1     = r_l[0];
    assign io_bus.l2     = r_l[1];
    assign io_bus.l3     = r_l[2];
    assign io_bus.l4     = r_l[3];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
// Self-checking bench for disp_scan_ctrl with a small configuration
// (PRESCALE=4, BLINK_TICKS=2, HOLD_TICKS=3, BLANK_PAT=FF). Inputs change on the
// falling edge, outputs are compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int P  = 4;
    localparam int BT = 2;
    localparam int H  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    disp_scan_ctrl_if bus ();

    disp_scan_ctrl #(
        .PRESCALE    (16'd4),
        .BLINK_TICKS (8'd2),
        .HOLD_TICKS  (8'd3),
        .BLANK_PAT   (8'hFF)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: everything is derived from the number of edges since
    // reset (mCyc) and the edge at which B was granted (mGrantCyc).
    int          mCyc;
    int          mGrantCyc;
    logic        mShowB;
    logic        mSrc;
    logic        mAck;
    logic        mEn;
    logic [31:0] mL;

    typedef struct {
        int          cyc;
        logic        en;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[10];

    // Model update for one rising edge, using the inputs held across it.
    task automatic modelStep();
        int   ticksSeen;
        int   t;
        logic phase;
        logic dark;
        if (reset) begin
            mCyc   = 0;
            mShowB = 1'b0;
            mSrc   = 1'b0;
            mAck   = 1'b0;
            mEn    = 1'b0;
            mL     = 32'hFFFF_FFFF;
        end else begin
            mCyc = mCyc + 1;
            mAck = 1'b0;
            if (!mShowB && bus.bReq) begin
                mShowB    = 1'b1;
                mAck      = 1'b1;
                mGrantCyc = mCyc;
            end else if (mShowB) begin
                ticksSeen = (mCyc - 1) / P - mGrantCyc / P;
                if (ticksSeen >= H && !bus.bReq) mShowB = 1'b0;
            end
            mSrc = mShowB;
            mEn  = (mCyc % P == 0);
            if (mEn) begin
                t     = mCyc / P;
                phase = (((t - 1) / BT) % 2) == 1;
                for (int d = 0; d < 4; d++) begin
                    dark = bus.blank || (phase && bus.blinkMask[d]);
                    mL[8*d +: 8] = dark ? 8'hFF : (mSrc ? bus.bData[8*d +: 8] : bus.aData[8*d +: 8]);
                end
            end
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, return at the falling edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic [31:0] b,
                                 input logic req, input logic [3:0] mask, input logic blnk);
        reset         = rst;
        bus.aData     = a;
        bus.bData     = b;
        bus.bReq      = req;
        bus.blinkMask = mask;
        bus.blank     = blnk;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, mCyc, actual, expected);
        end
    endtask

    function automatic logic [31:0] curL();
        return {bus.l4, bus.l3, bus.l2, bus.l1};
    endfunction

    task automatic checkModel(input string tag);
        checkOutput({tag, " L"},      curL(),             mL);
        checkOutput({tag, " SRC"},    {31'd0, bus.src},    {31'd0, mSrc});
        checkOutput({tag, " B_ACK"},  {31'd0, bus.bAck},   {31'd0, mAck});
        checkOutput({tag, " ENABLE"}, {31'd0, bus.enable}, {31'd0, mEn});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rreq;
        logic [3:0]  rmask;
        logic        rblank;

        tbl[0] = '{1,  1'b0, 32'hFFFF_FFFF};
        tbl[1] = '{3,  1'b0, 32'hFFFF_FFFF};
        tbl[2] = '{4,  1'b1, 32'h1122_3344};
        tbl[3] = '{5,  1'b0, 32'h1122_3344};
        tbl[4] = '{8,  1'b1, 32'h1122_3344};
        tbl[5] = '{12, 1'b1, 32'h1122_33FF};
        tbl[6] = '{16, 1'b1, 32'h1122_33FF};
        tbl[7] = '{20, 1'b1, 32'h1122_3344};
        tbl[8] = '{24, 1'b1, 32'h1122_3344};
        tbl[9] = '{28, 1'b1, 32'h1122_33FF};

        reset         = 1'b1;
        bus.aData     = '0;
        bus.bData     = '0;
        bus.bReq      = 1'b0;
        bus.blinkMask = '0;
        bus.blank     = 1'b0;
        @(negedge clk);

        // Reset state, then scan timing and blink of digit 1 from the table.
        $display("[TB] reset release and blink table");
        applyStimulus(1'b1, 32'h1122_3344, 32'h0, 1'b0, 4'b0001, 1'b0);
        checkOutput("reset L",      curL(),             32'hFFFF_FFFF);
        checkOutput("reset ENABLE", {31'd0, bus.enable}, 32'd0);
        checkOutput("reset SRC",    {31'd0, bus.src},    32'd0);
        checkOutput("reset B_ACK",  {31'd0, bus.bAck},   32'd0);
        for (int i = 0; i < 10; i++) begin
            while (mCyc < tbl[i].cyc) applyStimulus(1'b0, 32'h1122_3344, 32'h0, 1'b0, 4'b0001, 1'b0);
            checkOutput($sformatf("table%0d ENABLE", i), {31'd0, bus.enable}, {31'd0, tbl[i].en});
            checkOutput($sformatf("table%0d L", i),      curL(),             tbl[i].l);
            checkOutput($sformatf("table%0d SRC", i),    {31'd0, bus.src},    32'd0);
        end

        // One-cycle B request: grant at edge 6, B shown from tick at 8,
        // hold reaches 3 at edge 16, release at 17, A back on tick at 20.
        $display("[TB] B request pulse");
        applyStimulus(1'b1, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        while (mCyc < 5) applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b1, 4'b0000, 1'b0);
        checkOutput("pulse ack",    {31'd0, bus.bAck}, 32'd1);
        checkOutput("pulse src",    {31'd0, bus.src},  32'd1);
        applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        checkOutput("pulse ack low", {31'd0, bus.bAck}, 32'd0);
        checkOutput("pulse old L",   curL(),            32'h1122_3344);
        applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        checkOutput("pulse B L",     curL(),            32'hA0A1_A2A3);
        while (mCyc < 16) applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        checkOutput("pulse held src", {31'd0, bus.src}, 32'd1);
        applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        checkOutput("pulse release src", {31'd0, bus.src}, 32'd0);
        while (mCyc < 20) applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        checkOutput("pulse A back L", curL(), 32'h1122_3344);

        // Reset on what would be a tick edge while B is granted and requested.
        $display("[TB] reset during grant");
        applyStimulus(1'b1, 32'h1122_3344, 32'hA0A1_A2A3, 1'b0, 4'b0000, 1'b0);
        while (mCyc < 7) applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 32'h1122_3344, 32'hA0A1_A2A3, 1'b1, 4'b0000, 1'b0);
        checkOutput("midreset L",      curL(),             32'hFFFF_FFFF);
        checkOutput("midreset SRC",    {31'd0, bus.src},    32'd0);
        checkOutput("midreset ENABLE", {31'd0, bus.enable}, 32'd0);
        applyStimulus(1'b0, 32'h1122_3344, 32'hA0A1_A2A3, 1'b1, 4'b0000, 1'b0);
        checkOutput("midreset reack",  {31'd0, bus.bAck},   32'd1);

        // Randomised run against the reference model; B_REQ toggles rarely
        // so long requests and hold expiry both occur.
        $display("[TB] random run");
        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0);
        checkModel("rand reset");
        rreq   = 1'b0;
        rblank = 1'b0;
        rmask  = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) rreq   = ~rreq;
            if ($urandom_range(0, 63) == 0) rblank = ~rblank;
            if ($urandom_range(0, 99) == 0) rmask  = 4'($urandom);
            applyStimulus(($urandom_range(0, 599) == 0), ra, rb, rreq, rmask, rblank);
            checkModel("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
